// File: rtl/relu_pass_ctrl_pkg.sv
// Shared types for the ReLU pass controller: element type, FSM states, output select.
// RELU_PASS_CTRL_LEAKY_EN selects leaky ReLU (slope 1/8) instead of hard zero.
package relu_pass_ctrl_pkg;

    localparam int DATA_W      = 16;
    localparam int LEAKY_SHIFT = 3;
    localparam int WIN_FWD     = 0;
    localparam int WIN_BWD     = 1;

    typedef logic signed [DATA_W-1:0] data_type;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        BWD,
        DRAIN
    } state_t;

    // Pass-through when the element is kept, otherwise zero (or the leaky slope).
    function automatic data_type relu_sel(input data_type d, input logic keep);
        data_type r;
        if (keep) begin
            r = d;
        end else begin
`ifdef RELU_PASS_CTRL_LEAKY_EN
            r = d >>> LEAKY_SHIFT;
`else
            r = '0;
`endif
        end
        return r;
    endfunction

endpackage

// File: rtl/relu_pass_arb.sv
// Two-way round-robin arbiter choosing between forward and backward passes.
module relu_pass_arb
    import relu_pass_ctrl_pkg::*;
(
    input  logic       en,
    input  logic       fwd_el,
    input  logic       bwd_el,
    input  logic       last_bwd,
    output logic [1:0] win
);

    always_comb begin
        win = '0;
        if (en) begin
            if (fwd_el && bwd_el) begin
                // Both eligible: serve the one that did not go last.
                win[WIN_FWD] = last_bwd;
                win[WIN_BWD] = !last_bwd;
            end else begin
                win[WIN_FWD] = fwd_el;
                win[WIN_BWD] = bwd_el;
            end
        end
    end

endmodule

// File: rtl/relu_pass_ctrl.sv
// Shared element-wise ReLU datapath sequencing forward and backward passes of M elements.
// Build option RELU_PASS_CTRL_LEAKY_EN (in the package) switches to leaky ReLU outputs.
module relu_pass_ctrl
    import relu_pass_ctrl_pkg::*;
#(
    parameter int M = 5
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     fwd_req,
    input  logic     bwd_req,
    output logic     fwd_gnt,
    output logic     bwd_gnt,
    input  logic     in_valid,
    input  data_type in_data,
    output logic     in_ready,
    output logic     out_valid,
    output data_type out_data,
    input  logic     out_ready,
    output logic     mask_valid,
    output logic     done
);

    localparam int            CW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    mask;
    logic            last_bwd;
    data_type        out_q;
    logic            out_v;
    logic [1:0]      win;
    logic            in_acc;
    logic            out_take;
    logic            z_keep;

    relu_pass_arb u_arb (
        .en       (state == IDLE),
        .fwd_el   (fwd_req),
        .bwd_el   (bwd_req && mask_valid),
        .last_bwd (last_bwd),
        .win      (win)
    );

    // Single-entry output register: accept only if it is empty or draining this cycle.
    assign in_ready  = ((state == FWD) || (state == BWD)) && (!out_v || out_ready);
    assign in_acc    = in_valid && in_ready;
    assign out_take  = out_v && out_ready;
    assign done      = (state == DRAIN) && out_take;
    assign out_valid = out_v;
    assign out_data  = out_q;
    assign z_keep    = !in_data[DATA_W-1];

    // last_bwd is updated at grant, so in DRAIN it still names the pass in flight.
    assign fwd_gnt = (state == FWD) || ((state == DRAIN) && !last_bwd);
    assign bwd_gnt = (state == BWD) || ((state == DRAIN) && last_bwd);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (win[WIN_BWD])      state_n = BWD;
                else if (win[WIN_FWD]) state_n = FWD;
            end
            FWD, BWD: begin
                if (in_acc && (cnt == LAST)) state_n = DRAIN;
            end
            DRAIN: begin
                if (out_take) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mask       <= '0;
            last_bwd   <= 1'b1;
            out_q      <= '0;
            out_v      <= 1'b0;
            mask_valid <= 1'b0;
        end else begin
            state <= state_n;
            if ((state == IDLE) && (|win)) begin
                cnt      <= '0;
                last_bwd <= win[WIN_BWD];
            end
            if (in_acc) begin
                cnt   <= cnt + 1'b1;
                out_q <= relu_sel(in_data, (state == FWD) ? z_keep : mask[cnt]);
                if (state == FWD) mask[cnt] <= z_keep;
            end
            if (in_acc)        out_v <= 1'b1;
            else if (out_take) out_v <= 1'b0;
            if (done && !last_bwd) mask_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_relu_pass_ctrl.sv
// Self-checking bench for relu_pass_ctrl: directed table, alternation, random passes, mid-pass reset.
module tb_relu_pass_ctrl;
    import relu_pass_ctrl_pkg::*;

    localparam int M = 5;

    logic     clk = 1'b0;
    logic     reset, fwd_req, bwd_req, fwd_gnt, bwd_gnt;
    logic     in_valid, in_ready, out_valid, out_ready, mask_valid, done;
    data_type in_data, out_data;

    relu_pass_ctrl #(.M(M)) dut (
        .clk(clk), .reset(reset),
        .fwd_req(fwd_req), .bwd_req(bwd_req), .fwd_gnt(fwd_gnt), .bwd_gnt(bwd_gnt),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mask_valid(mask_valid), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model state
    data_type exp_q[$];
    data_type got_q[$];
    bit       pass_types[$];
    bit       mmask[M];
    bit       m_mvalid, pass_fwd, prev_gnt, last_acc, last_done;
    int       mcnt, gcyc, done_gcyc, done_cnt;
    int       drv_d[M];

    function automatic data_type model_out(input bit fwd, input data_type z, input bit mb);
        int  zi;
        bit  keep;
        zi   = int'(z);
        keep = fwd ? (zi >= 0) : mb;
        if (keep) return z;
`ifdef RELU_PASS_CTRL_LEAKY_EN
        return data_type'((zi < 0) ? (zi - 7) / 8 : zi / 8);
`else
        return data_type'(0);
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < M; i++) mmask[i] = 1'b0;
        m_mvalid = 1'b0;
        pass_fwd = 1'b0;
        prev_gnt = 1'b0;
        mcnt     = 0;
        gcyc     = 0;
    endtask

    // Called at a negedge after inputs are driven; observes the upcoming posedge's handshakes.
    task automatic step();
        bit       gnt;
        data_type e;
        #1;
        gnt       = fwd_gnt || bwd_gnt;
        last_acc  = 1'b0;
        last_done = 1'b0;
        chk("mask_valid", int'(mask_valid), int'(m_mvalid));
        chk("gnt_onehot", int'(fwd_gnt && bwd_gnt), 0);
        if (gnt && !prev_gnt) begin
            pass_fwd = fwd_gnt;
            mcnt     = 0;
            gcyc     = 0;
            pass_types.push_back(fwd_gnt);
        end
        if (gnt) gcyc++;
        if (out_valid && !out_ready) chk("in_ready_stall", int'(in_ready), 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", int'(out_data), int'(e));
            end
            got_q.push_back(out_data);
        end
        if (in_valid && in_ready) begin
            chk("in_ready_gnt", int'(gnt), 1);
            if (mcnt < M) begin
                e = model_out(pass_fwd, in_data, mmask[mcnt]);
                exp_q.push_back(e);
                if (pass_fwd) mmask[mcnt] = (int'(in_data) >= 0);
            end else begin
                chk("extra_input", mcnt, M - 1);
            end
            mcnt++;
            last_acc = 1'b1;
        end
        if (done) begin
            last_done = 1'b1;
            done_gcyc = gcyc;
            done_cnt++;
            chk("done_count", mcnt, M);
            chk("done_drained", exp_q.size(), 0);
            if (pass_fwd) m_mvalid = 1'b1;
        end
        prev_gnt = gnt;
        @(negedge clk);
    endtask

    // mode 0: no stalls; mode 1: out_ready 1,0,0,1; mode 2: random gaps and backpressure
    task automatic run_pass(input bit fwd, input int mode);
        int idx = 0;
        int cyc = 0;
        bit granted = 1'b0;
        bit fin = 1'b0;
        bit rpat[4];
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        got_q.delete();
        while (!fin && cyc < 80) begin
            fwd_req  = fwd && !granted;
            bwd_req  = !fwd && !granted;
            in_valid = (idx < M) && ((mode != 2) || ($urandom_range(0, 3) != 0));
            in_data  = (idx < M) ? data_type'(drv_d[idx]) : data_type'(0);
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = rpat[cyc % 4];
            else                out_ready = ($urandom_range(0, 1) == 1);
            step();
            if (last_acc) idx++;
            if (prev_gnt) granted = 1'b1;
            if (last_done) fin = 1'b1;
            cyc++;
        end
        fwd_req = 1'b0; bwd_req = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("pass_timeout", int'(fin), 1);
        chk("pass_len", got_q.size(), M);
    endtask

    typedef struct {
        bit fwd;
        int mode;
        int d[M];
        int e[M];
    } vec_t;

    vec_t tv[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, cyc, acc;

        tv[0].fwd = 1'b1; tv[0].mode = 0; tv[0].d = '{-3, 0, 7, -1, 4};
        tv[1].fwd = 1'b0; tv[1].mode = 0; tv[1].d = '{10, 20, 30, 40, 50};
        tv[2].fwd = 1'b1; tv[2].mode = 1; tv[2].d = '{5, -8, -100, 0, 32767};
        tv[3].fwd = 1'b0; tv[3].mode = 2; tv[3].d = '{-16, -16, -16, -16, -16};
        tv[4].fwd = 1'b1; tv[4].mode = 0; tv[4].d = '{-32768, 1, -1, 2, -2};
`ifdef RELU_PASS_CTRL_LEAKY_EN
        tv[0].e = '{-1, 0, 7, -1, 4};
        tv[1].e = '{1, 20, 30, 5, 50};
        tv[2].e = '{5, -1, -13, 0, 32767};
        tv[3].e = '{-16, -2, -2, -16, -16};
        tv[4].e = '{-4096, 1, -1, 2, -1};
`else
        tv[0].e = '{0, 0, 7, 0, 4};
        tv[1].e = '{0, 20, 30, 0, 50};
        tv[2].e = '{5, 0, 0, 0, 32767};
        tv[3].e = '{-16, 0, 0, -16, -16};
        tv[4].e = '{0, 1, 0, 2, 0};
`endif

        reset = 1'b0; fwd_req = 1'b0; bwd_req = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        done_cnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fwd_gnt", int'(fwd_gnt), 0);
        chk("rst_bwd_gnt", int'(bwd_gnt), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_mask_valid", int'(mask_valid), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;

        // Backward without a completed forward pass must stay pending
        bwd_req = 1'b1;
        repeat (10) begin
            step();
            chk("bwd_blocked", int'(bwd_gnt), 0);
        end
        bwd_req = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            drv_d = tv[i].d;
            run_pass(tv[i].fwd, tv[i].mode);
            for (int j = 0; j < M; j++)
                if (j < got_q.size()) chk($sformatf("tbl%0d_out%0d", i, j), int'(got_q[j]), tv[i].e[j]);
            if (tv[i].mode == 0) chk("done_cycle", done_gcyc, M + 1);
            chk("gnt_drop", int'(fwd_gnt || bwd_gnt), 0);
            step();
        end

        // Both requesting continuously: last pass was forward, so backward goes first
        pass_types.delete();
        fwd_req = 1'b1; bwd_req = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        start = done_cnt;
        cyc = 0;
        while ((done_cnt - start) < 5 && cyc < 200) begin
            in_data = data_type'($urandom_range(0, 65535) - 32768);
            step();
            cyc++;
        end
        fwd_req = 1'b0; bwd_req = 1'b0; in_valid = 1'b0;
        chk("alt_passes", pass_types.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < pass_types.size()) chk($sformatf("alt_order%0d", k), int'(pass_types[k]), k % 2);
        step();
        step();
        chk("alt_idle", int'(fwd_gnt || bwd_gnt), 0);

        // Random passes against the model
        repeat (10) begin
            for (int j = 0; j < M; j++) drv_d[j] = $urandom_range(0, 65535) - 32768;
            run_pass(($urandom_range(0, 1) == 1), 2);
            step();
        end

        // Reset after the third accepted element of a forward pass
        drv_d = '{-5, 6, -7, 8, 9};
        acc = 0;
        cyc = 0;
        fwd_req = 1'b1; out_ready = 1'b1;
        while (acc < 3 && cyc < 40) begin
            in_valid = 1'b1;
            in_data  = data_type'(drv_d[acc]);
            step();
            if (prev_gnt) fwd_req = 1'b0;
            if (last_acc) acc++;
            cyc++;
        end
        chk("midrst_accepts", acc, 3);
        reset = 1'b0;
        in_valid = 1'b0;
        fwd_req = 1'b0;
        #1;
        chk("midrst_fwd_gnt", int'(fwd_gnt), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_mask_valid", int'(mask_valid), 0);
        chk("midrst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        bwd_req = 1'b1;
        repeat (10) begin
            step();
            chk("midrst_bwd_blocked", int'(bwd_gnt), 0);
        end
        bwd_req = 1'b0;
        step();

        // Recovery: forward then backward with the fresh mask
        drv_d = tv[0].d;
        run_pass(1'b1, 0);
        step();
        drv_d = tv[1].d;
        run_pass(1'b0, 0);
        for (int j = 0; j < M; j++)
            if (j < got_q.size()) chk($sformatf("recov_out%0d", j), int'(got_q[j]), tv[1].e[j]);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
